// File: rtl/set_task_driver.sv
// Host-side task driver for the SET candidate-counting engine.
// Holds a small task table, issues tasks one at a time over en/busy/valid,
// captures each candidate, and keeps pass/fail totals plus a result buffer.
module set_task_driver #(
    parameter  int DEPTH   = 8,
    parameter  int TIMEOUT = 1023,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [23:0]   wr_central,
    input  logic [11:0]   wr_radius,
    input  logic [1:0]    wr_mode,
    input  logic [7:0]    wr_expect,
    input  logic          start,
    input  logic [CW-1:0] num_tasks,
    output logic          set_en,
    output logic [23:0]   set_central,
    output logic [11:0]   set_radius,
    output logic [1:0]    set_mode,
    input  logic          set_busy,
    input  logic          set_valid,
    input  logic [7:0]    set_candidate,
    output logic          run,
    output logic          done,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt,
    output logic          timeout_err,
    input  logic [AW-1:0] rd_idx,
    output logic [7:0]    rd_candidate,
    output logic          rd_match
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t                     state_q, state_d;
    logic [AW-1:0]              idx_q, idx_d;
    logic [CW-1:0]              n_q, n_d;
    logic [TW-1:0]              tcnt_q, tcnt_d;
    logic                       set_en_q, set_en_d;
    logic [23:0]                central_q, central_d;
    logic [11:0]                radius_q, radius_d;
    logic [1:0]                 mode_q, mode_d;
    logic                       run_q, run_d;
    logic                       done_q, done_d;
    logic [CW-1:0]              pass_q, pass_d;
    logic [CW-1:0]              fail_q, fail_d;
    logic                       terr_q, terr_d;
    logic [DEPTH-1:0][7:0]      res_q, res_d;
    logic [DEPTH-1:0]           match_q, match_d;

    // Task table: plain storage, no reset needed
    logic [23:0] tbl_central [DEPTH];
    logic [11:0] tbl_radius  [DEPTH];
    logic [1:0]  tbl_mode    [DEPTH];
    logic [7:0]  tbl_expect  [DEPTH];

    logic hit;
    assign hit = (set_candidate == tbl_expect[idx_q]);

    // Table writes are locked out for the whole run so issued data stays coherent
    always_ff @(posedge clk) begin
        if (wr_en && !run_q) begin
            tbl_central[wr_idx] <= wr_central;
            tbl_radius[wr_idx]  <= wr_radius;
            tbl_mode[wr_idx]    <= wr_mode;
            tbl_expect[wr_idx]  <= wr_expect;
        end
    end

    // Next-state and datapath updates for the issue/wait/capture sequence
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        tcnt_d    = tcnt_q;
        set_en_d  = 1'b0;
        central_d = central_q;
        radius_d  = radius_q;
        mode_d    = mode_q;
        run_d     = run_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        fail_d    = fail_q;
        terr_d    = terr_q;
        res_d     = res_q;
        match_d   = match_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    terr_d  = 1'b0;
                    res_d   = '0;
                    match_d = '0;
                    run_d   = 1'b1;
                    n_d     = (num_tasks > CW'(DEPTH)) ? CW'(DEPTH) : num_tasks;
                    state_d = (num_tasks == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                central_d = tbl_central[idx_q];
                radius_d  = tbl_radius[idx_q];
                mode_d    = tbl_mode[idx_q];
                if (!set_busy) begin
                    set_en_d = 1'b1;
                    tcnt_d   = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // busy is ignored here: the engine raises it a cycle or two after en
                tcnt_d = tcnt_q + TW'(1);
                if (set_valid) begin
                    res_d[idx_q]   = set_candidate;
                    match_d[idx_q] = hit;
                    if (hit) begin
                        if (pass_q != CW'(DEPTH)) pass_d = pass_q + CW'(1);
                    end else begin
                        if (fail_q != CW'(DEPTH)) fail_d = fail_q + CW'(1);
                    end
                    if (CW'(idx_q) == n_q - CW'(1)) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = ISSUE;
                    end
                end else if (tcnt_d == TW'(TIMEOUT)) begin
                    // abandon the rest of the run
                    if (fail_q != CW'(DEPTH)) fail_d = fail_q + CW'(1);
                    terr_d  = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                run_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any run immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            tcnt_q    <= '0;
            set_en_q  <= 1'b0;
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= '0;
            fail_q    <= '0;
            terr_q    <= 1'b0;
            res_q     <= '0;
            match_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            tcnt_q    <= tcnt_d;
            set_en_q  <= set_en_d;
            central_q <= central_d;
            radius_q  <= radius_d;
            mode_q    <= mode_d;
            run_q     <= run_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            terr_q    <= terr_d;
            res_q     <= res_d;
            match_q   <= match_d;
        end
    end

    assign set_en       = set_en_q;
    assign set_central  = central_q;
    assign set_radius   = radius_q;
    assign set_mode     = mode_q;
    assign run          = run_q;
    assign done         = done_q;
    assign pass_cnt     = pass_q;
    assign fail_cnt     = fail_q;
    assign timeout_err  = terr_q;
    assign rd_candidate = res_q[rd_idx];
    assign rd_match     = match_q[rd_idx];

endmodule

// File: tb/tb_set_task_driver.sv
// Scoreboard bench for set_task_driver with a behavioural SET engine model.
module tb_set_task_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic [23:0] wr_central = '0;
    logic [11:0] wr_radius = '0;
    logic [1:0]  wr_mode = '0;
    logic [7:0]  wr_expect = '0;
    logic        start = 1'b0;
    logic [3:0]  num_tasks = '0;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy;
    logic        set_valid = 1'b0;
    logic [7:0]  set_candidate = '0;
    logic        run, done, timeout_err;
    logic [3:0]  pass_cnt, fail_cnt;
    logic [2:0]  rd_idx = '0;
    logic [7:0]  rd_candidate;
    logic        rd_match;

    set_task_driver dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_central(wr_central),
        .wr_radius(wr_radius), .wr_mode(wr_mode), .wr_expect(wr_expect), .start(start),
        .num_tasks(num_tasks), .set_en(set_en), .set_central(set_central),
        .set_radius(set_radius), .set_mode(set_mode), .set_busy(set_busy),
        .set_valid(set_valid), .set_candidate(set_candidate), .run(run), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_err(timeout_err),
        .rd_idx(rd_idx), .rd_candidate(rd_candidate), .rd_match(rd_match)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] tbl_c [8];
    logic [11:0] tbl_r [8];
    logic [1:0]  tbl_m [8];
    logic [7:0]  tbl_e [8];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, en_total = 0, last_en_cyc = -100, last_v_cyc = -100;
    int lat = 3, stable_err = 0;
    logic never_valid = 1'b0, busy_force = 1'b0, eng_busy = 1'b0, eng_act = 1'b0;
    int eng_cnt = 0;
    logic [23:0] cap_c;
    logic [11:0] cap_r;
    logic [1:0]  cap_m;

    assign set_busy = eng_busy | busy_force;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int in_c(input int x, input int y, input int cx, input int cy, input int rr);
        return ((x - cx) * (x - cx) + (y - cy) * (y - cy) <= rr * rr) ? 1 : 0;
    endfunction

    // Reference candidate count over the 16x16 grid
    function automatic logic [7:0] set_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        int cnt, a, b, cc, k;
        cnt = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                a  = in_c(x, y, c[23:20], c[19:16], r[11:8]);
                b  = in_c(x, y, c[15:12], c[11:8],  r[7:4]);
                cc = in_c(x, y, c[7:4],   c[3:0],   r[3:0]);
                case (m)
                    2'd0: k = a;
                    2'd1: k = a & b;
                    2'd2: k = a ^ b;
                    default: k = (a + b + cc == 2) ? 1 : 0;
                endcase
                cnt += k;
            end
        end
        return cnt[7:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: latch task on en, raise busy, return candidate after lat cycles
    always @(posedge clk) begin
        set_valid <= 1'b0;
        if (rst || done) begin
            eng_act  <= 1'b0;
            eng_busy <= 1'b0;
        end else if (!eng_act) begin
            if (set_en) begin
                eng_act <= 1'b1;
                eng_cnt <= 0;
                cap_c   <= set_central;
                cap_r   <= set_radius;
                cap_m   <= set_mode;
            end
        end else begin
            eng_cnt  <= eng_cnt + 1;
            eng_busy <= 1'b1;
            if (set_central != cap_c || set_radius != cap_r || set_mode != cap_m)
                stable_err <= stable_err + 1;
            if (!never_valid && eng_cnt == lat) begin
                set_valid     <= 1'b1;
                set_candidate <= set_count(cap_c, cap_r, cap_m);
                eng_act       <= 1'b0;
                eng_busy      <= 1'b0;
            end
        end
    end

    // Monitor: every issue is popped from the scoreboard and checked
    initial forever begin
        exp_t t;
        @(negedge clk);
        if (set_en) begin
            en_total++;
            chk("en_gap", ((cyc - last_v_cyc) >= 1) ? 1 : 0, 1);
            last_en_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("en_extra", 1, 0);
            end else begin
                t = exp_q.pop_front();
                chk("central", set_central, t.c);
                chk("radius", set_radius, t.r);
                chk("mode", set_mode, t.m);
            end
        end
        if (set_valid) last_v_cyc = cyc;
    end

    task automatic wr_task(input int i, input logic [23:0] c, input logic [11:0] r,
                           input logic [1:0] m, input logic [7:0] e);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_idx = i[2:0]; wr_central = c; wr_radius = r; wr_mode = m; wr_expect = e;
        tbl_c[i] = c; tbl_r[i] = r; tbl_m[i] = m; tbl_e[i] = e;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) chk("done_timeout", 0, 1);
    endtask

    // Run nreq tasks, optionally poking start/wr_en mid-run or writing slot 2 with start
    task automatic run_tasks(input int nreq, input bit poke, input bit wsame, output int dlat, output int dcyc);
        int n, en0, np, nf, st;
        logic [7:0] cand;
        exp_t t;
        n = (nreq > 8) ? 8 : nreq;
        en0 = en_total; np = 0; nf = 0;
        @(posedge clk); #1;
        start = 1'b1; num_tasks = nreq[3:0];
        if (wsame) begin
            wr_en = 1'b1; wr_idx = 3'd2; wr_central = 24'h335300; wr_radius = 12'h220; wr_mode = 2'd1;
            wr_expect = set_count(24'h335300, 12'h220, 2'd1);
            tbl_c[2] = wr_central; tbl_r[2] = wr_radius; tbl_m[2] = wr_mode; tbl_e[2] = wr_expect;
        end
        st = cyc;
        for (int k = 0; k < n; k++) begin
            t.c = tbl_c[k]; t.r = tbl_r[k]; t.m = tbl_m[k];
            exp_q.push_back(t);
        end
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        if (poke) begin
            for (int i = 0; i < 100 && en_total == en0; i++) @(negedge clk);
            @(posedge clk); #1;
            start = 1'b1; num_tasks = 4'd1;
            wr_en = 1'b1; wr_idx = 3'd0; wr_central = 24'hFFFFFF; wr_expect = 8'd0;
            @(posedge clk); #1;
            start = 1'b0; wr_en = 1'b0;
        end
        wait_done(dcyc);
        dlat = dcyc - st;
        for (int k = 0; k < n; k++) begin
            cand = set_count(tbl_c[k], tbl_r[k], tbl_m[k]);
            if (cand == tbl_e[k]) np++; else nf++;
        end
        chk("pass_cnt", pass_cnt, np);
        chk("fail_cnt", fail_cnt, nf);
        chk("timeout_err", timeout_err, 0);
        chk("run_low", run, 0);
        chk("en_count", en_total - en0, n);
        chk("sb_empty", exp_q.size(), 0);
        for (int k = 0; k < n; k++) begin
            rd_idx = k[2:0];
            #1;
            cand = set_count(tbl_c[k], tbl_r[k], tbl_m[k]);
            chk("rd_candidate", rd_candidate, cand);
            chk("rd_match", rd_match, (cand == tbl_e[k]) ? 1 : 0);
        end
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dl, dc, en0, rel, d0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_set_en", set_en, 0);
        chk("rst_run", run, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_central", set_central, 0);

        wr_task(0, 24'h440000, 12'h300, 2'd0, 8'd29);
        wr_task(1, 24'h440000, 12'h300, 2'd0, 8'd30);
        wr_task(2, 24'h557500, 12'h330, 2'd1, set_count(24'h557500, 12'h330, 2'd1));
        wr_task(3, 24'h668800, 12'h220, 2'd2, set_count(24'h668800, 12'h220, 2'd2));
        wr_task(4, 24'h665686, 12'h222, 2'd3, set_count(24'h665686, 12'h222, 2'd3));
        wr_task(5, 24'hAAAAAA, 12'h444, 2'd3, set_count(24'hAAAAAA, 12'h444, 2'd3));
        wr_task(6, 24'h22DD00, 12'h440, 2'd2, set_count(24'h22DD00, 12'h440, 2'd2));
        wr_task(7, 24'hF0F000, 12'h110, 2'd0, set_count(24'hF0F000, 12'h110, 2'd0));

        // single task, known answer
        run_tasks(1, 0, 0, dl, dc);
        chk("done_after_valid", dc - last_v_cyc, 2);
        rd_idx = 3'd0; #1;
        chk("cand0_29", rd_candidate, 29);
        chk("match0", rd_match, 1);

        // three tasks, slot 1 expectation wrong, slot 2 rewritten with start
        run_tasks(3, 0, 1, dl, dc);
        chk("pass3", pass_cnt, 2);
        chk("fail3", fail_cnt, 1);

        // empty run
        run_tasks(0, 0, 0, dl, dc);
        chk("empty_done_lat", dl, 2);

        // clamp to DEPTH, with start/wr_en poked mid-run
        lat = 1;
        run_tasks(12, 1, 0, dl, dc);
        lat = 3;

        // busy held at start withholds set_en (also proves slot 0 unchanged by the poke)
        busy_force = 1'b1;
        rel = 0;
        fork
            run_tasks(1, 0, 0, dl, dc);
            begin
                repeat (5) @(posedge clk);
                #1 busy_force = 1'b0;
                rel = cyc;
            end
        join
        chk("busy_hold", last_en_cyc - rel, 1);

        // timeout: engine never answers
        never_valid = 1'b1;
        en0 = en_total;
        @(posedge clk); #1;
        start = 1'b1; num_tasks = 4'd4;
        begin
            exp_t t;
            t.c = tbl_c[0]; t.r = tbl_r[0]; t.m = tbl_m[0];
            exp_q.push_back(t);
        end
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(dc);
        chk("to_latency", dc - last_en_cyc, 1024);
        chk("to_fail", fail_cnt, 1);
        chk("to_pass", pass_cnt, 0);
        chk("to_err", timeout_err, 1);
        chk("to_en_count", en_total - en0, 1);
        never_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("to_sticky", timeout_err, 1);

        // next run clears the sticky error
        run_tasks(2, 0, 0, dl, dc);

        // reset mid-run
        lat = 30;
        en0 = en_total;
        @(posedge clk); #1;
        start = 1'b1; num_tasks = 4'd4;
        for (int k = 0; k < 4; k++) begin
            exp_t t;
            t.c = tbl_c[k]; t.r = tbl_r[k]; t.m = tbl_m[k];
            exp_q.push_back(t);
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 50 && en_total == en0; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_set_en", set_en, 0);
        chk("mrst_run", run, 0);
        chk("mrst_done", done, 0);
        chk("mrst_pass", pass_cnt, 0);
        chk("mrst_fail", fail_cnt, 0);
        chk("mrst_terr", timeout_err, 0);
        exp_q.delete();
        en0 = en_total;
        d0 = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) d0++;
        end
        chk("mrst_no_en", en_total - en0, 0);
        chk("mrst_no_done", d0, 0);
        lat = 3;

        chk("data_stable", stable_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
